// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: operands are latched on start, then one
// full-adder slice with a registered carry processes them LSB-first.
module serial_addsub #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Co
);

    localparam int unsigned     CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic           co_q, co_d;
    logic           done_q, done_d;

    logic           b_eff;
    logic           sum_bit;
    logic           carry_next;
    logic [N-1:0]   res_next;

    // Subtraction reuses the adder slice: A + ~B + ~borrow_in, with the
    // carry-out inverted back into a borrow at the end.
    assign b_eff      = b_q[0] ^ sub_q;
    assign sum_bit    = a_q[0] ^ b_eff ^ carry_q;
    assign carry_next = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);
    assign res_next   = (res_q >> 1) | (N'(sum_bit) << (N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        co_d    = co_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub;
                    carry_d = Ci ^ sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_next;
                carry_d = carry_next;
                cnt_d   = cnt_q + CW'(1);
                // Results are published only on the final bit so S/Co stay frozen during RUN.
                if (cnt_q == LAST_BIT) begin
                    s_d     = res_next;
                    co_d    = carry_next ^ sub_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        S    = s_q;
        Co   = co_q;
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: N=4 and N=1 instances, vector tables,
// randomized operations against an arithmetic model, and multi-cycle corner cases.
module tb_serial_addsub;

    typedef struct {
        logic       sub;
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] expS;
        logic       expCo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start1;
    logic       sub;
    logic [3:0] a, b;
    logic       ci;
    logic       busy4, done4, co4;
    logic [3:0] s4;
    logic       busy1, done1, co1;
    logic [0:0] s1;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t n1Vecs[8];
    vec_t n4Vecs[8];

    serial_addsub #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub),
        .A(a), .B(b), .Ci(ci),
        .busy(busy4), .done(done4), .S(s4), .Co(co4)
    );

    serial_addsub #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub),
        .A(a[0:0]), .B(b[0:0]), .Ci(ci),
        .busy(busy1), .done(done1), .S(s1), .Co(co1)
    );

    always #5 clk = ~clk;

    // Reference arithmetic for the 4-bit instance, straight from the integer definitions.
    function automatic logic [4:0] modelAddSub(input logic subV, input int aV, input int bV, input int ciV);
        int t;
        logic [4:0] r;
        if (!subV) begin
            t = aV + bV + ciV;
            r = 5'(t % 32);
        end else begin
            t = (aV - bV - ciV + 32) % 16;
            r = {(aV < bV + ciV) ? 1'b1 : 1'b0, 4'(t)};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launch one operation and wait for done; inputs are scrambled while busy.
    task automatic applyStimulus(input bit useN1, input logic subV, input logic [3:0] aV,
                                 input logic [3:0] bV, input logic ciV,
                                 output logic [3:0] sOut, output logic coOut,
                                 output int latency, output bit stable);
        logic [3:0] prevS;
        logic       prevCo;
        logic       curDone;
        @(negedge clk);
        sub = subV; a = aV; b = bV; ci = ciV;
        if (useN1) start1 = 1'b1; else start4 = 1'b1;
        prevS  = useN1 ? {3'b000, s1} : s4;
        prevCo = useN1 ? co1 : co4;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        latency = 0;
        stable  = 1'b1;
        curDone = useN1 ? done1 : done4;
        while (!curDone && latency < 20) begin
            if ((useN1 ? {3'b000, s1} : s4) != prevS || (useN1 ? co1 : co4) != prevCo)
                stable = 1'b0;
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            ci  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            latency++;
            curDone = useN1 ? done1 : done4;
        end
        sOut  = useN1 ? {3'b000, s1} : s4;
        coOut = useN1 ? co1 : co4;
    endtask

    initial begin
        logic [3:0] gotS;
        logic       gotCo;
        int         lat;
        bit         stab;
        logic [4:0] expV;
        int         busyCount, doneCount, lastIdx;
        logic [3:0] capS;
        logic       capCo;

        n1Vecs[0] = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        n1Vecs[1] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 1'b0};
        n1Vecs[2] = '{1'b0, 4'd0, 4'd1, 1'b0, 4'd1, 1'b0};
        n1Vecs[3] = '{1'b0, 4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
        n1Vecs[4] = '{1'b0, 4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        n1Vecs[5] = '{1'b0, 4'd1, 4'd0, 1'b1, 4'd0, 1'b1};
        n1Vecs[6] = '{1'b0, 4'd1, 4'd1, 1'b0, 4'd0, 1'b1};
        n1Vecs[7] = '{1'b0, 4'd1, 4'd1, 1'b1, 4'd1, 1'b1};

        n4Vecs[0] = '{1'b0, 4'd6,  4'd7,  1'b1, 4'd14, 1'b0};
        n4Vecs[1] = '{1'b0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        n4Vecs[2] = '{1'b1, 4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        n4Vecs[3] = '{1'b1, 4'd3,  4'd9,  1'b1, 4'd9,  1'b1};
        n4Vecs[4] = '{1'b0, 4'd5,  4'd5,  1'b0, 4'd10, 1'b0};
        n4Vecs[5] = '{1'b0, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        n4Vecs[6] = '{1'b1, 4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        n4Vecs[7] = '{1'b1, 4'd7,  4'd7,  1'b0, 4'd0,  1'b0};

        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
        sub = 1'b0; a = 4'd0; b = 4'd0; ci = 1'b0;
        #12;
        checkOutput("reset.busy", int'(busy4), 0);
        checkOutput("reset.done", int'(done4), 0);
        checkOutput("reset.S",    int'(s4),    0);
        checkOutput("reset.Co",   int'(co4),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, n1Vecs[i].sub, n1Vecs[i].a, n1Vecs[i].b, n1Vecs[i].ci,
                          gotS, gotCo, lat, stab);
            checkOutput($sformatf("n1[%0d].S", i),  int'(gotS),  int'(n1Vecs[i].expS));
            checkOutput($sformatf("n1[%0d].Co", i), int'(gotCo), int'(n1Vecs[i].expCo));
            checkOutput($sformatf("n1[%0d].latency", i), lat, 1);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, n4Vecs[i].sub, n4Vecs[i].a, n4Vecs[i].b, n4Vecs[i].ci,
                          gotS, gotCo, lat, stab);
            checkOutput($sformatf("n4[%0d].S", i),  int'(gotS),  int'(n4Vecs[i].expS));
            checkOutput($sformatf("n4[%0d].Co", i), int'(gotCo), int'(n4Vecs[i].expCo));
            checkOutput($sformatf("n4[%0d].latency", i), lat, 4);
            checkOutput($sformatf("n4[%0d].stable", i), int'(stab), 1);
        end

        for (int i = 0; i < 40; i++) begin
            logic       rs;
            logic [3:0] ra, rb;
            logic       rc;
            rs = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            expV = modelAddSub(rs, int'(ra), int'(rb), int'(rc));
            applyStimulus(1'b0, rs, ra, rb, rc, gotS, gotCo, lat, stab);
            checkOutput($sformatf("rand[%0d].S", i),  int'(gotS),  int'(expV[3:0]));
            checkOutput($sformatf("rand[%0d].Co", i), int'(gotCo), int'(expV[4]));
            checkOutput($sformatf("rand[%0d].latency", i), lat, 4);
        end

        // Busy lockout: a second start with new operands mid-run must be ignored.
        @(negedge clk);
        sub = 1'b0; a = 4'd6; b = 4'd7; ci = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        busyCount = 0; doneCount = 0; capS = 4'd0; capCo = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (busy4) busyCount++;
            if (done4) begin
                doneCount++;
                capS  = s4;
                capCo = co4;
            end
            if (i == 1) begin
                start4 = 1'b1; a = 4'd1; b = 4'd1; sub = 1'b1;
            end
            if (i == 2) start4 = 1'b0;
        end
        checkOutput("lockout.S",         int'(capS),  13);
        checkOutput("lockout.Co",        int'(capCo), 0);
        checkOutput("lockout.doneCount", doneCount,   1);
        checkOutput("lockout.busyCount", busyCount,   4);

        // Back-to-back: start held high gives one result every N+1 cycles.
        @(negedge clk);
        sub = 1'b0; a = 4'd5; b = 4'd5; ci = 1'b0; start4 = 1'b1;
        doneCount = 0; lastIdx = -1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (done4) begin
                doneCount++;
                checkOutput($sformatf("b2b[%0d].S", i),  int'(s4),  10);
                checkOutput($sformatf("b2b[%0d].Co", i), int'(co4), 0);
                if (lastIdx >= 0) checkOutput($sformatf("b2b[%0d].interval", i), i - lastIdx, 5);
                lastIdx = i;
            end
        end
        checkOutput("b2b.doneCount", doneCount, 4);
        start4 = 1'b0;
        for (int i = 0; i < 10 && busy4; i++) @(negedge clk);
        checkOutput("b2b.idle", int'(busy4), 0);

        // Asynchronous reset between edges during the second RUN cycle.
        @(negedge clk);
        sub = 1'b0; a = 4'd6; b = 4'd7; ci = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", int'(busy4), 0);
        checkOutput("midReset.done", int'(done4), 0);
        checkOutput("midReset.S",    int'(s4),    0);
        checkOutput("midReset.Co",   int'(co4),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd2, 4'd2, 1'b0, gotS, gotCo, lat, stab);
        checkOutput("postReset.S",       int'(gotS),  4);
        checkOutput("postReset.Co",      int'(gotCo), 0);
        checkOutput("postReset.latency", lat,         4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
